// File: rtl/vga_capture.sv
// vga_capture: receive side of a VGA timing interface.
//   Registers active-low vga_hs/vga_vs and 12-bit vga_rgb, recovers the pixel
//   position, measures line/frame length and locks after LOCK_FRAMES
//   consecutive frames that match the configured timing.
// Ports:
//   clk, rst                  pixel clock, synchronous active-high reset
//   vga_hs, vga_vs, vga_rgb   incoming sync (active low) and pixel data
//   pix_valid/pix_x/pix_y/pix_data  active pixel stream, only while locked
//   frame_start               1-cycle pulse per detected vsync fall
//   line_len, frame_lines     last measured line (clocks) / frame (lines)
//   locked, timing_err        lock status, 1-cycle pulse on lock loss
//   frame_sum                 (only with `define FRAME_SUM_EN) per-frame sum
//                             of captured pixel data, latched at vsync fall;
//                             value is unreliable for frames not fully locked
module vga_capture #(
  parameter int unsigned H_DISP      = 640,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_DISP      = 480,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [11:0] vga_rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_data,
  output logic        frame_start,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        timing_err
`ifdef FRAME_SUM_EN
  ,
  output logic [15:0] frame_sum
`endif
);

  localparam logic [10:0] H_START   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END     = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BACK + V_DISP - 1);
  localparam logic [9:0]  X_OFF     = 10'(H_SYNC + H_BACK);
  localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      state;
  logic [3:0]  good_cnt;
  logic        hs_r, hs_rr, vs_r, vs_rr;
  logic [11:0] rgb_r;
  logic [10:0] h_cnt, h_next;
  logic [9:0]  v_cnt, v_next;
  logic [11:0] h_len;
  logic [10:0] v_len;
  logic        h_seen, line_bad;
  logic        hs_fall, vs_fall, h_sat, len_bad, frame_ok, lose, active, valid_next;

  // h_next/v_next are the coordinates of the sample now held in rgb_r; the
  // window decode works on them so stage 2 lands 2 clocks after the pins.
  always_comb begin
    hs_fall  = hs_rr & ~hs_r;
    vs_fall  = vs_rr & ~vs_r;
    h_len    = {1'b0, h_cnt} + 12'd1;
    v_len    = {1'b0, v_cnt} + 11'd1;
    h_sat    = ~hs_fall & (h_cnt == '1);
    len_bad  = hs_fall & h_seen & (h_len != H_TOTAL_W);
    frame_ok = (v_len == V_TOTAL_W);

    h_next = h_cnt;
    if (hs_fall)     h_next = '0;
    else if (!h_sat) h_next = h_cnt + 11'd1;

    v_next = v_cnt;
    if (vs_fall)                      v_next = '0;
    else if (hs_fall && v_cnt != '1)  v_next = v_cnt + 10'd1;

    lose       = (state == LOCKED) & (len_bad | h_sat | (vs_fall & ~frame_ok));
    active     = (h_next >= H_START) && (h_next <= H_END) &&
                 (v_next >= V_START) && (v_next <= V_END);
    valid_next = (state == LOCKED) & ~lose & active;
  end

  // Input stage, position counters, measurements and pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r        <= 1'b1;
      hs_rr       <= 1'b1;
      vs_r        <= 1'b1;
      vs_rr       <= 1'b1;
      rgb_r       <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_seen      <= 1'b0;
      line_bad    <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
    end else begin
      hs_r        <= vga_hs;
      hs_rr       <= hs_r;
      vs_r        <= vga_vs;
      vs_rr       <= vs_r;
      rgb_r       <= vga_rgb;
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      frame_start <= vs_fall;
      pix_valid   <= valid_next;
      if (hs_fall) begin
        line_len <= h_cnt + 11'd1;
        h_seen   <= 1'b1;
      end
      if (vs_fall) frame_lines <= v_cnt + 10'd1;
      // The frame verdict is taken from line_bad before this clear.
      if (vs_fall)                line_bad <= 1'b0;
      else if (len_bad || h_sat)  line_bad <= 1'b1;
      if (valid_next) begin
        pix_x    <= h_next[9:0] - X_OFF;
        pix_y    <= v_next - V_START;
        pix_data <= rgb_r;
      end
    end
  end

  // Lock state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      unique case (state)
        SEARCH: if (vs_fall) begin
          state    <= CHECK;
          good_cnt <= '0;
        end
        CHECK: if (vs_fall) begin
          if (frame_ok && !(line_bad || len_bad || h_sat)) begin
            good_cnt <= good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_N) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else begin
            good_cnt <= '0;
          end
        end
        LOCKED: if (lose) begin
          state      <= SEARCH;
          locked     <= 1'b0;
          timing_err <= 1'b1;
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef FRAME_SUM_EN
  logic [15:0] sum_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else if (vs_fall) begin
      frame_sum <= sum_acc;
      sum_acc   <= '0;
    end else if (valid_next) begin
      sum_acc <= sum_acc + {4'b0, rgb_r};
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture with a reduced timing (16x10 active, 28x18 total) so
// several full frames fit in a short run. A position/lock model driven by
// the same pin stream predicts every output each cycle; directed checks pin
// the model to hand-computed values.
module tb_vga_capture;
  localparam int unsigned HD = 16, HS = 4, HB = 3, HT = 28;
  localparam int unsigned VD = 10, VS = 2, VB = 3, VT = 18;
  localparam int unsigned LF = 2;

  logic        clk, rst, vga_hs, vga_vs;
  logic [11:0] vga_rgb;
  logic        pix_valid, frame_start, locked, timing_err;
  logic [9:0]  pix_x, pix_y, frame_lines;
  logic [11:0] pix_data;
  logic [10:0] line_len;
`ifdef FRAME_SUM_EN
  logic [15:0] frame_sum;
`endif

  vga_capture #(
    .H_DISP(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_DISP(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .timing_err(timing_err)
`ifdef FRAME_SUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int unsigned sat_to(input int unsigned v, input int unsigned m);
    return (v > m) ? m : v;
  endfunction

  // ---------------- model: positions from timestamps of sync falls ---------
  int unsigned m_t, m_thf, m_nh, m_good, m_acc;
  int          m_mode;  // 0 searching, 1 checking, 2 locked
  bit          m_seen, m_bad, m_phs, m_pvs, m_shs, m_svs;
  logic [11:0] m_srgb;
  bit          e_valid, e_fs, e_lock, e_terr;
  int unsigned e_x, e_y, e_data, e_ll, e_fl, e_sum;

  task automatic model_step();
    bit hf, vf, len_bad, sat, lose, fr_ok, act;
    int unsigned old_h, old_v, new_h, new_v;
    if (rst) begin
      m_t = 0; m_thf = 0; m_nh = 0; m_good = 0; m_acc = 0; m_mode = 0;
      m_seen = 0; m_bad = 0; m_phs = 1; m_pvs = 1; m_shs = 1; m_svs = 1; m_srgb = '0;
      e_valid = 0; e_fs = 0; e_lock = 0; e_terr = 0;
      e_x = 0; e_y = 0; e_data = 0; e_ll = 0; e_fl = 0; e_sum = 0;
      return;
    end
    hf = m_phs && !m_shs;
    vf = m_pvs && !m_svs;
    m_t++;
    old_h   = sat_to(m_t - 1 - m_thf, 2047);
    old_v   = sat_to(m_nh, 1023);
    len_bad = hf && m_seen && (old_h + 1 != HT);
    sat     = !hf && (old_h == 2047);
    fr_ok   = (old_v + 1 == VT);
    if (hf) begin e_ll = (old_h + 1) % 2048; m_seen = 1; m_thf = m_t; end
    if (vf) begin e_fl = (old_v + 1) % 1024; m_nh = 0; end
    else if (hf) m_nh++;
    new_h = sat_to(m_t - m_thf, 2047);
    new_v = sat_to(m_nh, 1023);
    lose  = (m_mode == 2) && (len_bad || sat || (vf && !fr_ok));
    act   = new_h >= HS + HB && new_h < HS + HB + HD && new_v >= VS + VB && new_v < VS + VB + VD;
    e_fs = vf; e_terr = lose;
    e_valid = (m_mode == 2) && !lose && act;
    if (e_valid) begin e_x = new_h - (HS + HB); e_y = new_v - (VS + VB); e_data = 32'(m_srgb); end
    if (vf) begin e_sum = m_acc; m_acc = 0; end
    if (e_valid) m_acc = (m_acc + 32'(m_srgb)) % 65536;
    if (lose) m_mode = 0;
    else if (vf) begin
      if (m_mode == 0) begin m_mode = 1; m_good = 0; end
      else if (m_mode == 1) begin
        if (fr_ok && !(m_bad || len_bad || sat)) begin
          m_good++;
          if (m_good == LF) m_mode = 2;
        end else m_good = 0;
      end
    end
    if (vf) m_bad = 0;
    else if (len_bad || sat) m_bad = 1;
    e_lock = (m_mode == 2);
    m_phs = m_shs; m_pvs = m_svs;
    m_shs = vga_hs; m_svs = vga_vs; m_srgb = vga_rgb;
  endtask

  // ---------------- observations for directed checks ----------------------
  int fs_count = 0, fs_cyc[16], lock_rise_cyc = -1, terr_count = 0, terr_ll = -1;
  int frame_valid = 0, frame_valid_last = 0, valid_total = 0;
  int first_cyc = -1, first_x, first_y, first_data, last_x, last_y, abc_cyc = -1;
  bit prev_locked = 0;

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      chk("pix_valid",   32'(pix_valid),   32'(e_valid));
      chk("pix_x",       32'(pix_x),       e_x);
      chk("pix_y",       32'(pix_y),       e_y);
      chk("pix_data",    32'(pix_data),    e_data);
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("line_len",    32'(line_len),    e_ll);
      chk("frame_lines", 32'(frame_lines), e_fl);
      chk("locked",      32'(locked),      32'(e_lock));
      chk("timing_err",  32'(timing_err),  32'(e_terr));
`ifdef FRAME_SUM_EN
      chk("frame_sum",   32'(frame_sum),   e_sum);
`endif
      if (frame_start === 1'b1) begin
        if (fs_count < 16) fs_cyc[fs_count] = cyc;
        fs_count++;
        frame_valid_last = frame_valid;
        frame_valid = 0;
      end
      if (pix_valid === 1'b1) begin
        frame_valid++; valid_total++;
        if (first_cyc < 0) begin
          first_cyc = cyc; first_x = 32'(pix_x); first_y = 32'(pix_y); first_data = 32'(pix_data);
        end
        last_x = 32'(pix_x); last_y = 32'(pix_y);
      end
      if (locked === 1'b1 && !prev_locked && lock_rise_cyc < 0) lock_rise_cyc = cyc;
      prev_locked = (locked === 1'b1);
      if (timing_err === 1'b1) begin terr_count++; terr_ll = 32'(line_len); end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, n_cmp=%0d n_err=%0d", n_cmp, n_err);
    $fatal(1);
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic send(input logic hs, input logic vs, input logic [11:0] rgb);
    vga_hs = hs; vga_vs = vs; vga_rgb = rgb;
    @(posedge clk); #1;
  endtask

  function automatic logic [11:0] pattern(input int mode, input int l, input int h);
    if (mode == 1) return 12'h00F;
    if (l == int'(VS + VB) && h == int'(HS + HB)) return 12'hABC;
    return 12'(l * 37 + h * 5 + 1);
  endfunction

  task automatic gen_frame(input int short_line, input int mode, input int rst_line);
    int len;
    logic [11:0] px;
    for (int l = 0; l < int'(VT); l++) begin
      len = (l == short_line) ? int'(HT) - 1 : int'(HT);
      for (int h = 0; h < len; h++) begin
        px = pattern(mode, l, h);
        if (l == rst_line && h == 10) rst = 1'b1;
        send(h >= int'(HS), l >= int'(VS), px);
        if (mode == 0 && px == 12'hABC) abc_cyc = cyc;
        if (rst) begin
          rst = 1'b0;
          chk("midrst_pix_valid",   32'(pix_valid),   0);
          chk("midrst_locked",      32'(locked),      0);
          chk("midrst_line_len",    32'(line_len),    0);
          chk("midrst_frame_lines", 32'(frame_lines), 0);
        end
      end
    end
  endtask

  initial begin
    int vt0;
    rst = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1; vga_rgb = '0;
    for (int i = 0; i < 3; i++) begin
      vga_hs = 1'($urandom_range(0, 1)); vga_vs = 1'($urandom_range(0, 1));
      vga_rgb = 12'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_locked",      32'(locked),      0);
    chk("rst_pix_valid",   32'(pix_valid),   0);
    chk("rst_line_len",    32'(line_len),    0);
    chk("rst_frame_lines", 32'(frame_lines), 0);
    rst = 1'b0;
    send(1, 1, 0); chk("post_rst_fs0", 32'(frame_start), 0);
    send(1, 1, 0); chk("post_rst_fs1", 32'(frame_start), 0);
    repeat (4) send(1, 1, 0);

    // Acquire lock with nominal frames.
    for (int f = 0; f < 3; f++) gen_frame(-1, 0, -1);
    chk("lock_fs_count",    32'(fs_count), 3);
    chk("lock_at_3rd_fs",   32'(lock_rise_cyc), 32'(fs_cyc[2]));
    chk("lock_locked",      32'(locked), 1);
    chk("lock_line_len",    32'(line_len), HT);
    chk("lock_frame_lines", 32'(frame_lines), VT);
    chk("first_pix_x",      32'(first_x), 0);
    chk("first_pix_y",      32'(first_y), 0);
    chk("first_pix_data",   32'(first_data), 32'h0ABC);
    chk("first_pix_latency", 32'(first_cyc - abc_cyc), 2);
    chk("last_pix_x",       32'(last_x), HD - 1);
    chk("last_pix_y",       32'(last_y), VD - 1);
    gen_frame(-1, 0, -1);
    chk("valid_per_frame",  32'(frame_valid_last), HD * VD);

    // Short line while locked, then relock.
    gen_frame(7, 0, -1);
    chk("short_terr_count", 32'(terr_count), 1);
    chk("short_line_len",   32'(terr_ll), HT - 1);
    chk("short_locked",     32'(locked), 0);
    gen_frame(-1, 0, -1);
    chk("short_frame_valid", 32'(frame_valid_last), 48);
    chk("relock_wait1",     32'(locked), 0);
    gen_frame(-1, 0, -1);
    chk("relock_wait2",     32'(locked), 0);
    chk("unlocked_valid",   32'(frame_valid_last), 0);
    gen_frame(-1, 1, -1);
    chk("relock_locked",    32'(locked), 1);
    chk("relock_terr",      32'(terr_count), 1);
    gen_frame(-1, 0, -1);
    chk("const_frame_valid", 32'(frame_valid_last), HD * VD);
`ifdef FRAME_SUM_EN
    chk("frame_sum_const",  32'(frame_sum), 32'h0960);
`endif

    // hsync stuck high: counter saturation drops lock.
    vt0 = valid_total;
    repeat (3000) send(1, 1, 0);
    repeat (2) send(1, 0, 0);
    repeat (50) send(1, 1, 0);
    repeat (2) send(1, 0, 0);
    repeat (10) send(1, 1, 0);
    chk("sat_terr_count",   32'(terr_count), 2);
    chk("sat_locked",       32'(locked), 0);
    chk("sat_frame_lines",  32'(frame_lines), 1);
    chk("sat_no_valid",     32'(valid_total - vt0), 0);

    // Relock, then reset in the middle of a locked frame.
    gen_frame(-1, 0, -1);
    gen_frame(-1, 0, -1);
    gen_frame(-1, 0, 8);
    gen_frame(-1, 0, -1);
    chk("after_midrst_locked", 32'(locked), 0);
    repeat (5) send(1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
